// File: rtl/uart_loader_if.sv
// Memory port-B write bus driven by the serial program loader.
//   mem_addr  : byte address of the current write
//   mem_wdata : assembled 32-bit little-endian word
//   mem_we    : write strobe
// master = loader (drives the bus), slave = memory / observer.
interface uart_loader_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;

    modport master (output mem_addr, output mem_wdata, output mem_we);
    modport slave  (input  mem_addr, input  mem_wdata, input  mem_we);
endinterface

// File: rtl/uart_loader.sv
// Serial program loader: receives a little-endian 32-bit word count N over
// 8N1 UART, then N little-endian words, and writes them to consecutive word
// addresses starting at BASE_ADDR through the memory port-B write bus.
//   clk      : sole clock, all state on posedge
//   rst_n    : asynchronous active-low reset
//   rx       : UART serial input (idle high, asynchronous to clk)
//   start    : single-cycle load request, honoured only when idle
//   busy     : load in progress
//   done/err : sticky completion / failure flags, cleared by next start
//   word_cnt : words written so far in this load
//   mem      : memory write bus (address, data, write strobe)
module uart_loader #(
    parameter int          CLK_FREQ  = 100_000_000,
    parameter int          BAUD      = 115200,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 16384
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   word_cnt,
    uart_loader_if.master mem
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    // ---------------- rx synchronizer + edge history ----------------
    logic sync1_reg, sync2_reg, rx_prev_reg;
    logic rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            sync1_reg   <= rx;
            sync2_reg   <= sync1_reg;
            rx_prev_reg <= sync2_reg;
        end
    end

    assign rx_s = sync2_reg;

    // ---------------- RX engine (free running) ----------------
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t        rx_state_reg, rx_state_next;
    logic [CNT_W-1:0] clk_cnt_reg, clk_cnt_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       rx_byte_reg, rx_byte_next;
    logic             byte_valid, frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_reg <= R_IDLE;
            clk_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            rx_byte_reg  <= '0;
        end else begin
            rx_state_reg <= rx_state_next;
            clk_cnt_reg  <= clk_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            rx_byte_reg  <= rx_byte_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        clk_cnt_next  = clk_cnt_reg + CNT_W'(1);
        bit_cnt_next  = bit_cnt_reg;
        rx_byte_next  = rx_byte_reg;
        byte_valid    = 1'b0;
        frame_err     = 1'b0;
        case (rx_state_reg)
            R_IDLE: begin
                clk_cnt_next = '0;
                if (rx_prev_reg && !rx_s) begin
                    rx_state_next = R_START;
                    bit_cnt_next  = '0;
                end
            end
            R_START: begin
                // mid start bit: a line back high was only a glitch
                if (clk_cnt_reg == HALF_LAST) begin
                    clk_cnt_next  = '0;
                    rx_state_next = rx_s ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (clk_cnt_reg == BIT_LAST) begin
                    clk_cnt_next = '0;
                    rx_byte_next = {rx_s, rx_byte_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7)
                        rx_state_next = R_STOP;
                end
            end
            R_STOP: begin
                if (clk_cnt_reg == BIT_LAST) begin
                    clk_cnt_next  = '0;
                    byte_valid    = rx_s;
                    frame_err     = !rx_s;
                    rx_state_next = R_IDLE;
                end
            end
            default: rx_state_next = R_IDLE;
        endcase
    end

    // ---------------- load FSM ----------------
    typedef enum logic [2:0] {L_IDLE, L_HDR, L_DATA, L_WRITE, L_DONE, L_ERR} load_state_t;

    load_state_t state_reg, state_next;
    logic [1:0]  byte_idx_reg, byte_idx_next;
    logic [1:0]  we_cnt_reg, we_cnt_next;
    logic [31:0] n_words_reg, n_words_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] addr_reg, addr_next;
    logic [15:0] word_cnt_reg, word_cnt_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic [31:0] hdr_word;
    logic [15:0] word_cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= L_IDLE;
            byte_idx_reg <= '0;
            we_cnt_reg   <= '0;
            n_words_reg  <= '0;
            wdata_reg    <= '0;
            addr_reg     <= BASE_ADDR;
            word_cnt_reg <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            byte_idx_reg <= byte_idx_next;
            we_cnt_reg   <= we_cnt_next;
            n_words_reg  <= n_words_next;
            wdata_reg    <= wdata_next;
            addr_reg     <= addr_next;
            word_cnt_reg <= word_cnt_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        byte_idx_next = byte_idx_reg;
        we_cnt_next   = we_cnt_reg;
        n_words_next  = n_words_reg;
        wdata_next    = wdata_reg;
        addr_next     = addr_reg;
        word_cnt_next = word_cnt_reg;
        done_next     = done_reg;
        err_next      = err_reg;
        // header value including the byte arriving this cycle
        hdr_word      = {rx_byte_reg, n_words_reg[31:8]};
        word_cnt_inc  = word_cnt_reg + 16'd1;
        case (state_reg)
            L_IDLE: begin
                if (start) begin
                    done_next     = 1'b0;
                    err_next      = 1'b0;
                    word_cnt_next = '0;
                    byte_idx_next = '0;
                    state_next    = L_HDR;
                end
            end
            L_HDR: begin
                if (frame_err) begin
                    state_next = L_ERR;
                end else if (byte_valid) begin
                    n_words_next  = hdr_word;
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        if (hdr_word == 32'd0) begin
                            state_next = L_DONE;
                        end else if (hdr_word > 32'(MAX_WORDS)) begin
                            state_next = L_ERR;
                        end else begin
                            state_next = L_DATA;
                            addr_next  = BASE_ADDR;
                        end
                    end
                end
            end
            L_DATA: begin
                if (frame_err) begin
                    state_next = L_ERR;
                end else if (byte_valid) begin
                    wdata_next    = {rx_byte_reg, wdata_reg[31:8]};
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        state_next  = L_WRITE;
                        we_cnt_next = '0;
                    end
                end
            end
            L_WRITE: begin
                // four-cycle strobe so the memory's 1-in-4 write phase is hit
                we_cnt_next = we_cnt_reg + 2'd1;
                if (we_cnt_reg == 2'd3) begin
                    word_cnt_next = word_cnt_inc;
                    addr_next     = addr_reg + 32'd4;
                    state_next    = ({16'd0, word_cnt_inc} == n_words_reg) ? L_DONE : L_DATA;
                end
            end
            L_DONE:  state_next = L_IDLE;
            L_ERR:   state_next = L_IDLE;
            default: state_next = L_IDLE;
        endcase
        // flags rise together with the state change so they lead busy's fall by zero cycles
        if (state_next == L_DONE) done_next = 1'b1;
        if (state_next == L_ERR)  err_next  = 1'b1;
    end

    assign busy          = (state_reg == L_HDR) || (state_reg == L_DATA) || (state_reg == L_WRITE);
    assign done          = done_reg;
    assign err           = err_reg;
    assign word_cnt      = word_cnt_reg;
    assign mem.mem_addr  = addr_reg;
    assign mem.mem_wdata = wdata_reg;
    assign mem.mem_we    = (state_reg == L_WRITE);
endmodule

// File: tb/tb_uart_loader.sv
`timescale 1ns/1ps
module tb_uart_loader;
    localparam int CLK_FREQ  = 1600;
    localparam int BAUD      = 100;
    localparam int CPB       = 16;
    localparam int MAX_WORDS = 16384;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx    = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [15:0] word_cnt;

    uart_loader_if mem_bus();

    uart_loader #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .word_cnt(word_cnt),
        .mem     (mem_bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          writes_seen = 0;

    // write monitor / scoreboard consumer: one line per completed burst
    initial begin : monitor
        int          we_run;
        logic        we_prev;
        logic [31:0] cap_addr, cap_data;
        wr_t         e;
        we_run  = 0;
        we_prev = 1'b0;
        cap_addr = '0;
        cap_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                we_run  = 0;
                we_prev = 1'b0;
            end else begin
                if (mem_bus.mem_we) begin
                    if (we_run == 0) begin
                        cap_addr = mem_bus.mem_addr;
                        cap_data = mem_bus.mem_wdata;
                    end else begin
                        checks++;
                        if (mem_bus.mem_addr !== cap_addr || mem_bus.mem_wdata !== cap_data) begin
                            failures++;
                            $display("FAIL we_stable: got addr=%08h data=%08h required addr=%08h data=%08h",
                                     mem_bus.mem_addr, mem_bus.mem_wdata, cap_addr, cap_data);
                        end
                    end
                    we_run++;
                end else if (we_prev) begin
                    writes_seen++;
                    checks++;
                    if (we_run !== 4) begin
                        failures++;
                        $display("FAIL we_len: got %0d cycles required 4", we_run);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_write: got addr=%08h data=%08h required no write", cap_addr, cap_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (cap_addr !== e.addr || cap_data !== e.data) begin
                            failures++;
                            $display("FAIL write_data: got addr=%08h data=%08h required addr=%08h data=%08h",
                                     cap_addr, cap_data, e.addr, e.data);
                        end else begin
                            $display("write addr=%08h data=%08h ok", cap_addr, cap_data);
                        end
                    end
                    we_run = 0;
                end
                we_prev = mem_bus.mem_we;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            send_byte(b, 1'b1);
        end
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_finish(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!busy && (done || err)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got busy=%0b done=%0b err=%0b required finish within 1000 cycles",
                     name, busy, done, err);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_end(input string name, input logic exp_done, input logic exp_err,
                             input logic [15:0] exp_cnt, input int exp_writes);
        checks++;
        if (done !== exp_done || err !== exp_err || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_flags: got done=%0b err=%0b busy=%0b required done=%0b err=%0b busy=0",
                     name, done, err, busy, exp_done, exp_err);
        end
        checks++;
        if (word_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL %s_word_cnt: got %0d required %0d", name, word_cnt, exp_cnt);
        end
        checks++;
        if (writes_seen !== exp_writes || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_writes: got %0d writes (%0d pending) required %0d writes (0 pending)",
                     name, writes_seen, exp_q.size(), exp_writes);
        end
        $display("%s: done=%0b err=%0b word_cnt=%0d writes=%0d", name, done, err, word_cnt, writes_seen);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || mem_bus.mem_we !== 1'b0 ||
            word_cnt !== 16'd0 || mem_bus.mem_addr !== 32'd0 || mem_bus.mem_wdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: got busy=%0b done=%0b err=%0b we=%0b cnt=%0d addr=%08h data=%08h required all zero",
                     busy, done, err, mem_bus.mem_we, word_cnt, mem_bus.mem_addr, mem_bus.mem_wdata);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        $display("reset: busy=%0b done=%0b err=%0b", busy, done, err);
    endtask

    task automatic test_basic;
        int w0;
        w0 = writes_seen;
        pulse_start;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy: got %0b required 1", busy);
        end
        push_exp(32'h0, 32'hDEADBEEF);
        push_exp(32'h4, 32'h12345678);
        send_word(32'd2);
        send_word(32'hDEADBEEF);
        send_word(32'h12345678);
        wait_finish("basic");
        check_end("basic", 1'b1, 1'b0, 16'd2, w0 + 2);
        checks++;
        if (mem_bus.mem_addr !== 32'h8) begin
            failures++;
            $display("FAIL basic_addr: got %08h required 00000008", mem_bus.mem_addr);
        end
    endtask

    task automatic test_zero;
        int w0;
        w0 = writes_seen;
        pulse_start;
        send_word(32'd0);
        wait_finish("zero");
        check_end("zero", 1'b1, 1'b0, 16'd0, w0);
    endtask

    task automatic test_too_many;
        int w0;
        w0 = writes_seen;
        pulse_start;
        send_word(32'(MAX_WORDS + 1));
        wait_finish("too_many");
        check_end("too_many", 1'b0, 1'b1, 16'd0, w0);
        pulse_start;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_clears_err: got err=%0b busy=%0b required err=0 busy=1", err, busy);
        end
        send_word(32'd0);
        wait_finish("restart");
        check_end("restart", 1'b1, 1'b0, 16'd0, w0);
    endtask

    task automatic test_frame_err;
        int w0;
        w0 = writes_seen;
        pulse_start;
        push_exp(32'h0, 32'h11223344);
        send_word(32'd3);
        send_word(32'h11223344);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b0);
        wait_finish("frame_err");
        check_end("frame_err", 1'b0, 1'b1, 16'd1, w0 + 1);
    endtask

    task automatic test_glitch_start;
        int w0;
        w0 = writes_seen;
        // glitch while idle must not raise err
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_glitch: got err=%0b busy=%0b required err=1 (sticky) busy=0", err, busy);
        end
        pulse_start;
        // glitch during header reception: a spurious byte would corrupt N
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL hdr_glitch: got err=%0b busy=%0b required err=0 busy=1", err, busy);
        end
        push_exp(32'h0, 32'hA1B2C3D4);
        push_exp(32'h4, 32'h0F1E2D3C);
        send_word(32'd2);
        send_word(32'hA1B2C3D4);
        pulse_start;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || word_cnt !== 16'd1) begin
            failures++;
            $display("FAIL start_in_data: got busy=%0b done=%0b cnt=%0d required busy=1 done=0 cnt=1",
                     busy, done, word_cnt);
        end
        send_word(32'h0F1E2D3C);
        wait_finish("glitch_start");
        check_end("glitch_start", 1'b1, 1'b0, 16'd2, w0 + 2);
    endtask

    task automatic test_reset_mid_write;
        int w0;
        bit seen;
        w0 = writes_seen;
        seen = 1'b0;
        pulse_start;
        send_word(32'd1);
        fork
            send_word(32'hA5A50F0F);
        join_none
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (mem_bus.mem_we) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL abort_we_timeout: got no mem_we required a write burst");
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_bus.mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
            word_cnt !== 16'd0 || mem_bus.mem_addr !== 32'd0 || mem_bus.mem_wdata !== 32'd0) begin
            failures++;
            $display("FAIL async_abort: got we=%0b busy=%0b done=%0b err=%0b cnt=%0d addr=%08h data=%08h required all zero",
                     mem_bus.mem_we, busy, done, err, word_cnt, mem_bus.mem_addr, mem_bus.mem_wdata);
        end
        repeat (30) @(negedge clk);
        rx = 1'b1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        $display("abort: reset applied during write burst");
        pulse_start;
        push_exp(32'h0, 32'hCAFEF00D);
        send_word(32'd1);
        send_word(32'hCAFEF00D);
        wait_finish("after_abort");
        check_end("after_abort", 1'b1, 1'b0, 16'd1, w0 + 1);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero;
        test_too_many;
        test_frame_err;
        test_glitch_start;
        test_reset_mid_write;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_loader.md
# uart_loader

Serial program loader sitting between the board UART RX pin and the data memory's port-B write path. On a `start` pulse it receives a little-endian 32-bit word count N over 8N1 UART, then N little-endian 32-bit words. Each word is written to memory at consecutive word addresses from `BASE_ADDR`. It drives the writer end of the memory's port-B interface while the CPU is held off, and reports `done` or `err` to the top level.

## Interface
- `CLK_FREQ`, default 100_000_000: clk frequency in Hz.
- `BAUD`, default 115200: UART bit rate; `CLKS_PER_BIT = CLK_FREQ / BAUD` (integer divide), must be ≥ 16.
- `BASE_ADDR`, default 32'h0000_0000: byte address of first word; word aligned.
- `MAX_WORDS`, default 16384: largest accepted N (64 KiB of memory).
- `clk`  in  1  sole clock; all state on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART serial input, idle high; asynchronous to clk.
- `start`  in  1  single-cycle request to begin a load.
- `busy`  out  1  high from accepted `start` until DONE/ERR.
- `done`  out  1  sticky; set when all N words are written; cleared by next accepted `start`.
- `err`  out  1  sticky; set on framing error or N > MAX_WORDS; cleared by next accepted `start`.
- `mem_addr`  out  32  byte address of current write.
- `mem_wdata`  out  32  assembled word.
- `mem_we`  out  1  write strobe to memory port B.
- `word_cnt`  out  16  words written so far in this load.

## Operation
- `rx` passes through a 2-flop synchronizer before use. The RX engine runs continuously, independent of the load FSM.
- RX engine states:
  - R_IDLE: a falling edge on synced rx goes to R_START with bit counter cleared.
  - R_START: at CLKS_PER_BIT/2, if rx is still 0 go to R_DATA; otherwise treat as a glitch and return to R_IDLE with no error.
  - R_DATA: sample at each further CLKS_PER_BIT, LSB first, 8 bits.
  - R_STOP: sample one bit time later. A 1 produces a one-cycle `byte_valid` carrying the byte. A 0 produces a one-cycle `frame_err`. Either way, return to R_IDLE.
- Load FSM states:
  - IDLE: `start` clears done, err and word_cnt, then goes to HDR.
  - HDR: shift in 4 bytes (byte0 = bits 7:0). After the 4th, if N == 0 go to DONE; if N > MAX_WORDS go to ERR; otherwise go to DATA with `mem_addr = BASE_ADDR`.
  - DATA: shift in 4 bytes into `mem_wdata`, little-endian. After the 4th, go to WRITE.
  - WRITE: hold `mem_we = 1` for exactly 4 consecutive cycles with `mem_addr` and `mem_wdata` stable. Four cycles guarantee the memory's 1-in-4 write phase is hit. On exit: `word_cnt += 1` and `mem_addr += 4`. Go to DONE if word_cnt reaches N, else return to DATA.
  - DONE: set `done` and go to IDLE.
  - ERR: set `err` and go to IDLE.
- `frame_err` in HDR or DATA goes to ERR immediately and discards the partial word; a pending WRITE still completes first. `frame_err` or `byte_valid` in IDLE is ignored.
- `start` outside IDLE is ignored.
- `mem_addr` wraps modulo 2^32 (unreachable with legal MAX_WORDS).

## Timing
- Reset: all outputs 0, `mem_addr = BASE_ADDR`, both FSMs idle, synchronizer flops set to 1.
- Reset mid-load aborts immediately; no write is in flight after `rst_n` rises.
- `busy` rises the cycle after `start` is sampled.
- `byte_valid` occurs about 9.5 bit-times (±1 clk, plus 2 sync cycles) after the start-bit falling edge.
- `mem_we` rises the cycle after the 4th byte's `byte_valid` and falls 4 cycles later.
- Since CLKS_PER_BIT ≥ 16, the next byte cannot complete during WRITE, so no RX byte is dropped.
- `done`/`err` rise one cycle after the final WRITE cycle or error event; `busy` falls in that same cycle.

## Test plan
- Bench parameters CLK_FREQ=1600, BAUD=100 (16 clk/bit). Reset, then `start`; send N=2 and words 0xDEADBEEF, 0x12345678 → exactly two 4-cycle `mem_we` bursts at addr 0x0 then 0x4 with those data; `word_cnt` = 2, `done` = 1, `busy` = 0.
- Header N=0 → `done` = 1 with no `mem_we` ever asserted.
- Header N=MAX_WORDS+1 → `err` = 1, no writes; a following `start` clears `err` and sets `busy`.
- Stop bit forced to 0 on the 2nd data byte → `err` = 1, no write for that word, earlier words keep their writes.
- A 3-clk low glitch on `rx` in R_IDLE → no `byte_valid`, no `err`. A `start` pulse during DATA → ignored and the load completes normally.
- `rst_n` asserted during the 2nd WRITE cycle → `mem_we` drops asynchronously, all outputs return to reset values, and a fresh load afterwards succeeds.
